// File: rtl/execute_pkg.sv
// Shared definitions for the execute stage.
// Holds the datapath width, register index width and the funct3 encodings
// for conditional branches and ALU operations, plus a branch-condition
// helper used by the execute top.
package execute_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  // Branch funct3 encodings (010 and 011 are reserved: never taken)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // ALU funct3 encodings
  localparam logic [2:0] F3_ADD  = 3'b000;  // sub when func7 = 1
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;  // sra when func7 = 1
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch condition on two source operands.
  function automatic logic branch_taken(input logic [2:0]      func3,
                                        input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic                   taken;
    a_s   = a;
    b_s   = b;
    taken = 1'b0;
    case (func3)
      F3_BEQ:  taken = (a == b);
      F3_BNE:  taken = (a != b);
      F3_BLT:  taken = (a_s <  b_s);
      F3_BGE:  taken = (a_s >= b_s);
      F3_BLTU: taken = (a <  b);
      F3_BGEU: taken = (a >= b);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/execute_if.sv
// Execute-stage bus: decoded instruction fields in, registered writeback
// and next-PC out.
//   slave  : the execute stage (consumes decode fields, drives results)
//   master : the decode side / environment (drives decode fields)
interface execute_if;
  import execute_pkg::*;

  logic             is_branch;
  logic             is_jump;
  logic             is_reg;
  logic             is_alu;
  logic             is_load;
  logic             is_store;
  logic             is_ui;
  logic             add_pc;
  logic [XLEN-1:0]  operand_a;
  logic [XLEN-1:0]  operand_b;
  logic [XLEN-1:0]  branch_dest;
  logic [XLEN-1:0]  curr_pc;
  logic [REG_W-1:0] dest_i;
  logic [2:0]       func3;
  logic             func7;
  logic [XLEN-1:0]  result;
  logic [REG_W-1:0] dest_o;
  logic [XLEN-1:0]  next_pc;

  modport slave (
    input  is_branch, is_jump, is_reg, is_alu, is_load, is_store, is_ui,
           add_pc, operand_a, operand_b, branch_dest, curr_pc, dest_i,
           func3, func7,
    output result, dest_o, next_pc
  );

  modport master (
    output is_branch, is_jump, is_reg, is_alu, is_load, is_store, is_ui,
           add_pc, operand_a, operand_b, branch_dest, curr_pc, dest_i,
           func3, func7,
    input  result, dest_o, next_pc
  );

endinterface

// File: rtl/execute_alu.sv
// Combinational integer ALU.
// Ports: operand_a, operand_b (32) in; func3 (3) op select; func7 (1)
// selects sub/sra; result (32) out. Shift amount is operand_b[4:0].
module alu
  import execute_pkg::*;
(
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [2:0]      func3,
  input  logic            func7,
  output logic [XLEN-1:0] result
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic        [4:0]      shamt;

  assign a_s   = operand_a;
  assign b_s   = operand_b;
  assign shamt = operand_b[4:0];

  always_comb begin
    result = '0;
    case (func3)
      F3_ADD:  result = func7 ? (operand_a - operand_b) : (operand_a + operand_b);
      F3_SLL:  result = operand_a << shamt;
      F3_SLT:  result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      F3_SLTU: result = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
      F3_XOR:  result = operand_a ^ operand_b;
      F3_SR:   result = func7 ? XLEN'(a_s >>> shamt) : (operand_a >> shamt);
      F3_OR:   result = operand_a | operand_b;
      F3_AND:  result = operand_a & operand_b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/execute.sv
// RISC-V execute stage: one-cycle latency, no stalls.
// Ports: clk, reset (async, active-high), bus (execute_if.slave) carrying
// decode flags, operands, branch offset, current PC, dest index, func3/func7
// in, and registered result, dest_o (0 = no writeback), next_pc out.
// Decode priority: branch > jump > alu > load/store > upper-immediate.
module execute
  import execute_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  execute_if.slave bus
);

  logic [XLEN-1:0]  alu_out;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  ab_sum;
  logic [XLEN-1:0]  result_p0;
  logic [REG_W-1:0] dest_p0;
  logic [XLEN-1:0]  next_pc_p0;
  logic [XLEN-1:0]  result_p1;
  logic [REG_W-1:0] dest_p1;
  logic [XLEN-1:0]  next_pc_p1;

  alu u_alu (
    .operand_a (bus.operand_a),
    .operand_b (bus.operand_b),
    .func3     (bus.func3),
    .func7     (bus.func7),
    .result    (alu_out)
  );

  assign pc_plus4 = bus.curr_pc + XLEN'(4);
  assign ab_sum   = bus.operand_a + bus.operand_b;

  // Stage p0: decode select and writeback/PC formation
  always_comb begin
    result_p0  = '0;
    dest_p0    = '0;
    next_pc_p0 = pc_plus4;
    if (bus.is_branch) begin
      if (branch_taken(bus.func3, bus.operand_a, bus.operand_b))
        next_pc_p0 = bus.curr_pc + bus.branch_dest;
    end else if (bus.is_jump) begin
      result_p0 = pc_plus4;
      if (bus.is_reg) begin
        next_pc_p0 = {ab_sum[XLEN-1:1], 1'b0};
        dest_p0    = bus.dest_i;
      end else begin
        next_pc_p0 = bus.curr_pc + bus.operand_a;
        // JAL with no link register still links into x1
        dest_p0    = (bus.dest_i == '0) ? REG_W'(1) : bus.dest_i;
      end
    end else if (bus.is_alu) begin
      result_p0 = alu_out;
      dest_p0   = bus.dest_i;
    end else if (bus.is_load || bus.is_store) begin
      result_p0 = ab_sum;
      dest_p0   = bus.is_load ? bus.dest_i : '0;
    end else if (bus.is_ui) begin
      result_p0 = bus.add_pc ? (bus.curr_pc + bus.operand_a) : bus.operand_a;
      dest_p0   = bus.dest_i;
    end
  end

  // Stage p1: registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_p1  <= '0;
      dest_p1    <= '0;
      next_pc_p1 <= '0;
    end else begin
      result_p1  <= result_p0;
      dest_p1    <= dest_p0;
      next_pc_p1 <= next_pc_p0;
    end
  end

  assign bus.result  = result_p1;
  assign bus.dest_o  = dest_p1;
  assign bus.next_pc = next_pc_p1;

endmodule

// File: tb/tb_execute.sv
// Testbench for the execute stage: directed vectors, reset behaviour and
// randomized instructions checked against a behavioural model.
module tb_execute;
  import execute_pkg::*;

  // flag vector layout: {is_branch, is_jump, is_reg, is_alu, is_load, is_store, is_ui, add_pc}
  localparam logic [7:0] BR   = 8'b1000_0000;
  localparam logic [7:0] JAL  = 8'b0100_0000;
  localparam logic [7:0] JALR = 8'b0110_0000;
  localparam logic [7:0] ALU  = 8'b0001_0000;
  localparam logic [7:0] LD   = 8'b0000_1000;
  localparam logic [7:0] ST   = 8'b0000_0100;
  localparam logic [7:0] LUI  = 8'b0000_0010;
  localparam logic [7:0] AUI  = 8'b0000_0011;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  dest;
    logic [31:0] npc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  execute_if bus ();

  execute dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check({tag, ".result"},  bus.result,         e.result);
    check({tag, ".dest_o"},  {27'd0, bus.dest_o}, {27'd0, e.dest});
    check({tag, ".next_pc"}, bus.next_pc,        e.npc);
  endtask

  task automatic drive(input logic [7:0] fl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] off, input logic [31:0] pc, input logic [4:0] d,
                       input logic [2:0] f3, input logic f7);
    bus.is_branch   = fl[7];
    bus.is_jump     = fl[6];
    bus.is_reg      = fl[5];
    bus.is_alu      = fl[4];
    bus.is_load     = fl[3];
    bus.is_store    = fl[2];
    bus.is_ui       = fl[1];
    bus.add_pc      = fl[0];
    bus.operand_a   = a;
    bus.operand_b   = b;
    bus.branch_dest = off;
    bus.curr_pc     = pc;
    bus.dest_i      = d;
    bus.func3       = f3;
    bus.func7       = f7;
  endtask

  // Drive one instruction, let one rising edge pass, compare outputs.
  task automatic go(input string tag, input logic [7:0] fl, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] off, input logic [31:0] pc,
                    input logic [4:0] d, input logic [2:0] f3, input logic f7,
                    input logic [31:0] er, input logic [4:0] ed, input logic [31:0] enpc);
    exp_t e;
    e.result = er;
    e.dest   = ed;
    e.npc    = enpc;
    drive(fl, a, b, off, pc, d, f3, f7);
    @(posedge clk);
    #1;
    check_out(tag, e);
  endtask

  // Behavioural reference: instruction semantics written with plain
  // integer arithmetic (shifts as multiply/divide by powers of two).
  function automatic exp_t model(input logic [7:0] fl, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] off,
                                 input logic [31:0] pc, input logic [4:0] d,
                                 input logic [2:0] f3, input logic f7);
    exp_t        e;
    int          sa, sb, sh;
    longint      ua, ub, p, q;
    logic [63:0] wide;
    logic        taken;
    sa = a;  sb = b;
    ua = {32'd0, a};  ub = {32'd0, b};
    sh = int'(b % 32);
    p  = longint'(1) << sh;
    e.result = 32'd0;
    e.dest   = 5'd0;
    e.npc    = pc + 32'd4;
    if (fl[7]) begin
      case (f3)
        3'd0: taken = (ua == ub);
        3'd1: taken = (ua != ub);
        3'd4: taken = (sa < sb);
        3'd5: taken = !(sa < sb);
        3'd6: taken = (ua < ub);
        3'd7: taken = !(ua < ub);
        default: taken = 1'b0;
      endcase
      if (taken) e.npc = pc + off;
    end else if (fl[6]) begin
      e.result = pc + 32'd4;
      if (fl[5]) begin
        wide  = 64'(ua + ub);
        e.npc = wide[31:0] - (wide[31:0] % 2);
        e.dest = d;
      end else begin
        e.npc  = pc + a;
        e.dest = (d == 5'd0) ? 5'd1 : d;
      end
    end else if (fl[4]) begin
      e.dest = d;
      case (f3)
        3'd0: e.result = f7 ? 32'(ua - ub) : 32'(ua + ub);
        3'd1: begin wide = 64'(ua) * 64'(p); e.result = wide[31:0]; end
        3'd2: e.result = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: e.result = (ua < ub) ? 32'd1 : 32'd0;
        3'd4: e.result = a ^ b;
        3'd5: begin
          if (f7) begin
            q = longint'(sa) / p;
            if (sa < 0 && (longint'(sa) % p) != 0) q = q - 1;  // floor division
            e.result = 32'(q);
          end else begin
            e.result = 32'(ua / p);
          end
        end
        3'd6: e.result = a | b;
        default: e.result = a & b;
      endcase
    end else if (fl[3] || fl[2]) begin
      e.result = 32'(ua + ub);
      e.dest   = fl[3] ? d : 5'd0;
    end else if (fl[1]) begin
      e.result = fl[0] ? (pc + a) : a;
      e.dest   = d;
    end
    return e;
  endfunction

  initial begin
    exp_t        e;
    exp_t        zero;
    logic [7:0]  fl;
    logic [31:0] a, b, off, pc;
    logic [4:0]  d;
    logic [2:0]  f3;
    logic        f7;

    zero.result = 32'd0;
    zero.dest   = 5'd0;
    zero.npc    = 32'd0;

    drive(8'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 3'd0, 1'b0);
    reset = 1'b1;
    #3;
    check_out("reset_async", zero);
    @(posedge clk);
    #1;
    check_out("reset_held", zero);
    @(negedge clk);
    reset = 1'b0;

    // branches
    go("beq",  BR, 32'd200, 32'd200, 32'd20, 32'd20, 5'd3, F3_BEQ, 1'b0, 32'd0, 5'd0, 32'd40);
    go("blt",  BR, 32'd100, 32'(-300), 32'd20, 32'd40, 5'd3, F3_BLT, 1'b0, 32'd0, 5'd0, 32'd44);
    go("bge",  BR, 32'd100, 32'd100, 32'd16, 32'd12, 5'd3, F3_BGE, 1'b0, 32'd0, 5'd0, 32'd28);
    go("bltu", BR, 32'd2200000000, 32'd10, 32'd100, 32'd20, 5'd3, F3_BLTU, 1'b0, 32'd0, 5'd0, 32'd24);
    go("brsv", BR, 32'd5, 32'd5, 32'd100, 32'd20, 5'd3, 3'b010, 1'b0, 32'd0, 5'd0, 32'd24);
    // jumps
    go("jal",  JAL, 32'd20000, 32'd0, 32'd0, 32'd20, 5'd0, 3'd0, 1'b0, 32'd24, 5'd1, 32'd20020);
    go("jalr", JALR, 32'd32, 32'd16, 32'd0, 32'd4, 5'd11, 3'd0, 1'b0, 32'd8, 5'd11, 32'd48);
    go("jalr_odd", JALR, 32'd33, 32'd16, 32'd0, 32'd4, 5'd7, 3'd0, 1'b0, 32'd8, 5'd7, 32'd48);
    // ALU
    go("add",  ALU, 32'd100, 32'(-200), 32'd0, 32'd8, 5'd5, F3_ADD, 1'b0, 32'(-100), 5'd5, 32'd12);
    go("sub",  ALU, 32'd10, 32'(-10), 32'd0, 32'd8, 5'd6, F3_ADD, 1'b1, 32'd20, 5'd6, 32'd12);
    go("sll",  ALU, 32'hDAD1F3A7, 32'h0083F510, 32'd0, 32'd8, 5'd7, F3_SLL, 1'b0, 32'hF3A70000, 5'd7, 32'd12);
    go("srl",  ALU, 32'h4E94F2F4, 32'h00000108, 32'd0, 32'd8, 5'd8, F3_SR, 1'b0, 32'h004E94F2, 5'd8, 32'd12);
    go("sra",  ALU, 32'hF9936F04, 32'd24, 32'd0, 32'd8, 5'd9, F3_SR, 1'b1, 32'hFFFFFFF9, 5'd9, 32'd12);
    go("slt",  ALU, 32'(-200), 32'd100, 32'd0, 32'd8, 5'd10, F3_SLT, 1'b0, 32'd1, 5'd10, 32'd12);
    go("sltu", ALU, 32'd2300000000, 32'd200, 32'd0, 32'd8, 5'd12, F3_SLTU, 1'b0, 32'd0, 5'd12, 32'd12);
    // upper immediate / memory
    go("lui",   LUI, 32'd8192, 32'd0, 32'd0, 32'd4, 5'd13, 3'd0, 1'b0, 32'd8192, 5'd13, 32'd8);
    go("auipc", AUI, 32'd8192, 32'd0, 32'd0, 32'd4, 5'd14, 3'd0, 1'b0, 32'd8196, 5'd14, 32'd8);
    go("store", ST, 32'd100, 32'd8, 32'd0, 32'd16, 5'd15, 3'd2, 1'b0, 32'd108, 5'd0, 32'd20);
    go("load",  LD, 32'd100, 32'd8, 32'd0, 32'd16, 5'd15, 3'd2, 1'b0, 32'd108, 5'd15, 32'd20);
    go("none",  8'd0, 32'd100, 32'd8, 32'd0, 32'hFFFFFFFC, 5'd15, 3'd0, 1'b0, 32'd0, 5'd0, 32'd0);
    // priority: branch wins over an X on jump
    drive(BR, 32'd1, 32'd2, 32'd8, 32'd100, 5'd4, F3_BNE, 1'b0);
    bus.is_jump = 1'bx;
    bus.is_alu  = 1'bx;
    @(posedge clk);
    #1;
    e.result = 32'd0; e.dest = 5'd0; e.npc = 32'd108;
    check_out("prio_x", e);

    // reset mid-operation: pending result discarded, outputs clear at once
    drive(ALU, 32'd1, 32'd2, 32'd0, 32'd40, 5'd9, F3_ADD, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_out("reset_mid", zero);
    @(posedge clk);
    #1;
    check_out("reset_mid_edge", zero);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    e.result = 32'd3; e.dest = 5'd9; e.npc = 32'd44;
    check_out("reset_release", e);

    // randomized instructions
    for (int i = 0; i < 400; i++) begin
      fl  = 8'($urandom) & 8'($urandom);
      a   = $urandom();
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom();
      off = $urandom();
      pc  = $urandom();
      d   = 5'($urandom);
      f3  = 3'($urandom);
      f7  = 1'($urandom);
      e   = model(fl, a, b, off, pc, d, f3, f7);
      go($sformatf("rand%0d", i), fl, a, b, off, pc, d, f3, f7, e.result, e.dest, e.npc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 Parameters: none; all widths fixed (XLEN 32, register index 5).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 is_branch  input  1  conditional branch instruction.
REQ-005 is_jump  input  1  jump instruction; with is_reg=1 it is JALR, else JAL.
REQ-006 is_reg  input  1  register-relative jump qualifier.
REQ-007 is_alu  input  1  register or immediate ALU operation.
REQ-008 is_load / is_store  input  1 each  memory access instruction.
REQ-009 is_ui  input  1  upper-immediate instruction; add_pc  input  1  AUIPC when 1, LUI when 0.
REQ-010 operand_a, operand_b  input  32 each  source operands (register values or immediates).
REQ-011 branch_dest  input  32  PC-relative branch offset.
REQ-012 curr_pc  input  32  PC of the instruction being executed.
REQ-013 dest_i  input  5  destination register index from decode.
REQ-014 func3  input  3  RISC-V funct3; func7  input  1  funct7 bit 5 (sub/sra select).
REQ-015 result  output  32  registered writeback value.
REQ-016 dest_o  output  5  registered writeback register index; 0 means no writeback.
REQ-017 next_pc  output  32  registered next program counter.

Function
REQ-018 Outputs update one clock after inputs are presented; each cycle is independent, with no stall or handshake.
REQ-019 Decode priority: is_branch, then is_jump, then is_alu, then is_load/is_store, then is_ui, then none. An X/0 on a lower-priority flag does not affect a higher-priority selection.
REQ-020 Branch: taken when func3 selects 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu on operand_a vs operand_b. Taken gives next_pc = curr_pc + branch_dest; not taken gives curr_pc + 4. dest_o = 0; result = 0. Reserved func3 values are not taken.
REQ-021 JAL (is_jump=1, is_reg=0): result = curr_pc + 4; next_pc = curr_pc + operand_a; dest_o = dest_i, except dest_i = 0 gives dest_o = 1.
REQ-022 JALR (is_jump=1, is_reg=1): result = curr_pc + 4; next_pc = (operand_a + operand_b) with bit 0 cleared; dest_o = dest_i.
REQ-023 ALU by func3: 000 add (func7=0) / sub (func7=1); 001 sll; 010 slt signed; 011 sltu; 100 xor; 101 srl (func7=0) / sra (func7=1); 110 or; 111 and. Set ops produce 0 or 1.
REQ-024 Shift amount is operand_b[4:0]; upper bits are ignored.
REQ-025 ALU: next_pc = curr_pc + 4; dest_o = dest_i.
REQ-026 Load/store: result = operand_a + operand_b (effective address); next_pc = curr_pc + 4; dest_o = dest_i for load, 0 for store.
REQ-027 UI: result = operand_a (LUI) or curr_pc + operand_a (AUIPC); next_pc = curr_pc + 4; dest_o = dest_i.
REQ-028 No flag set: result = 0; dest_o = 0; next_pc = curr_pc + 4.
REQ-029 All additions wrap modulo 2^32, with no overflow flags.

Reset
REQ-030 While reset=1: result, dest_o and next_pc are 0 immediately, independent of clk.
REQ-031 Reset asserted mid-operation discards the pending result; the first edge after release computes from the current inputs.

Structure
REQ-032 Shared package holds the func3 constants for branch and ALU encodings, plus XLEN = 32.
REQ-033 One sub-module, alu: combinational, with operand_a, operand_b, func3 and func7 in and 32-bit out; execute owns the registers and the PC logic.

Verification
REQ-034 Reset: assert reset -> result = 0, dest_o = 0, next_pc = 0.
REQ-035 Branches: beq 200/200, pc 20, off 20 -> next_pc 40, dest_o 0; blt 100/-300, pc 40 -> 44; bge 100/100, pc 12, off 16 -> 28; bltu 2200000000/10, pc 20 -> 24.
REQ-036 Jumps: jal a = 20000, pc 20, dest_i 0 -> result 24, next_pc 20020, dest_o 1; jalr 32 + 16, pc 4, dest_i 11 -> result 8, next_pc 48, dest_o 11.
REQ-037 ALU:
- add 100 + -200 -> -100
- sub 10 - -10 -> 20
- sll 0xDAD1F3A7 by b = 0x0083F510 -> 0xF3A70000
- srl 0x4E94F2F4 by b[4:0] = 8 -> 0x004E94F2
- sra 0xF9936F04 by 24 -> 0xFFFFFFF9
- slt -200 < 100 -> 1
- sltu 2300000000 < 200 -> 0
- each gives next_pc = pc + 4 and dest_o = dest_i
REQ-038 UI/memory: lui a = 8192, pc 4 -> result 8192, next_pc 8; auipc a = 8192, pc 4 -> 8196; store 100 + 8 -> result 108, dest_o 0; load -> dest_o = dest_i.
